// File: rtl/gen_scheduler_pkg.sv
// Shared types for the generation scheduler: loader config requests and FSM states.
package gen_scheduler_pkg;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    NO_REQ   = 2'd0,
    MEM_INIT = 2'd1,
    CFG_1    = 2'd2,
    CFG_2    = 2'd3
  } load_cfg_req_t;

  typedef enum logic [2:0] {
    INIT_GO    = 3'd0,
    INIT_WAIT  = 3'd1,
    IDLE       = 3'd2,
    SIM_START  = 3'd3,
    SIM_BUSY   = 3'd4,
    LOAD_START = 3'd5,
    LOAD_BUSY  = 3'd6
  } gen_sched_state_t;

  // One-entry pending load: cfg_1 wins a tie, a newer pulse overwrites, a take empties it.
  function automatic load_cfg_req_t next_pending(input load_cfg_req_t cur, input logic cfg_1,
                                                 input logic cfg_2, input logic take);
    load_cfg_req_t nxt;
    nxt = cur;
    if (cfg_1) begin
      nxt = CFG_1;
    end else if (cfg_2) begin
      nxt = CFG_2;
    end else if (take) begin
      nxt = NO_REQ;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gen_frame_divider.sv
// Counts frame pulses modulo FRAMES_PER_GEN; o_wrap_c flags the pulse that completes a period.
module gen_frame_divider
  import gen_scheduler_pkg::*;
#(
  parameter int unsigned FRAMES_PER_GEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_frame,
  input  logic i_clear,
  output logic o_wrap_c
);

  localparam logic [FRAME_CNT_W-1:0] LAST = FRAME_CNT_W'(FRAMES_PER_GEN - 1);

  logic [FRAME_CNT_W-1:0] r_cnt;

  // A clear in the same cycle suppresses the wrap so a pause toggle never races a start.
  assign o_wrap_c = i_frame && !i_clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_frame) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: rtl/gen_scheduler.sv
// Sequences simulator generations and config loads; optional generation counter under GEN_SCHED_GEN_CNT_EN.
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int unsigned FRAMES_PER_GEN = 4,
  parameter int unsigned GEN_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_toggle_pause,
  input  logic             i_cmd_step,
  input  logic             i_cmd_load_cfg_1,
  input  logic             i_cmd_load_cfg_2,
  input  logic             i_frame_start,
  input  logic             i_nfi_busy,
  input  logic             i_fcl_busy,
  output logic             o_nfi_go,
  output logic             o_fcl_go,
  output load_cfg_req_t    o_load_req,
  output logic             o_paused,
  output logic [GEN_W-1:0] o_gen_cnt
);

  gen_sched_state_t r_state, w_state_nxt;
  load_cfg_req_t    r_load_req, w_load_req_nxt, r_pend;
  logic             r_nfi_go, r_fcl_go, r_paused, r_step_pend, r_init_sent;
  logic             w_nfi_go_nxt, w_fcl_go_nxt, w_take_load, w_take_step;
  logic             w_wrap, w_any_busy;

  assign w_any_busy = i_nfi_busy || i_fcl_busy;

  gen_frame_divider #(
    .FRAMES_PER_GEN(FRAMES_PER_GEN)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_frame (i_frame_start),
    .i_clear (i_cmd_toggle_pause),
    .o_wrap_c(w_wrap)
  );

  // Next state and next registered outputs; go pulses are raised on the edge entering *_START.
  always_comb begin
    w_state_nxt    = r_state;
    w_nfi_go_nxt   = 1'b0;
    w_fcl_go_nxt   = 1'b0;
    w_load_req_nxt = r_load_req;
    w_take_load    = 1'b0;
    w_take_step    = 1'b0;
    case (r_state)
      INIT_GO: begin
        w_load_req_nxt = MEM_INIT;
        if (!r_init_sent) begin
          w_fcl_go_nxt = !w_any_busy;
        end else if (i_fcl_busy) begin
          w_state_nxt = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (!i_fcl_busy) begin
          w_state_nxt    = IDLE;
          w_load_req_nxt = NO_REQ;
        end
      end
      IDLE: begin
        if (!w_any_busy) begin
          if (r_pend != NO_REQ) begin
            w_state_nxt    = LOAD_START;
            w_fcl_go_nxt   = 1'b1;
            w_load_req_nxt = r_pend;
            w_take_load    = 1'b1;
          end else if (r_step_pend) begin
            w_state_nxt  = SIM_START;
            w_nfi_go_nxt = 1'b1;
            w_take_step  = 1'b1;
          end else if (!r_paused && w_wrap) begin
            w_state_nxt  = SIM_START;
            w_nfi_go_nxt = 1'b1;
          end
        end
      end
      SIM_START: if (i_nfi_busy) w_state_nxt = SIM_BUSY;
      SIM_BUSY:  if (!i_nfi_busy) w_state_nxt = IDLE;
      LOAD_START: if (i_fcl_busy) w_state_nxt = LOAD_BUSY;
      LOAD_BUSY: begin
        if (!i_fcl_busy) begin
          w_state_nxt    = IDLE;
          w_load_req_nxt = NO_REQ;
        end
      end
      default: w_state_nxt = INIT_GO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_GO;
      r_nfi_go    <= 1'b0;
      r_fcl_go    <= 1'b0;
      r_load_req  <= NO_REQ;
      r_paused    <= 1'b1;
      r_pend      <= NO_REQ;
      r_step_pend <= 1'b0;
      r_init_sent <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_nfi_go    <= w_nfi_go_nxt;
      r_fcl_go    <= w_fcl_go_nxt;
      r_load_req  <= w_load_req_nxt;
      r_pend      <= next_pending(r_pend, i_cmd_load_cfg_1, i_cmd_load_cfg_2, w_take_load);
      if (i_cmd_toggle_pause) r_paused <= !r_paused;
      if (i_cmd_step && r_paused) begin
        r_step_pend <= 1'b1;
      end else if (w_take_step) begin
        r_step_pend <= 1'b0;
      end
      if (r_state == INIT_GO && w_fcl_go_nxt) r_init_sent <= 1'b1;
    end
  end

`ifdef GEN_SCHED_GEN_CNT_EN
  logic [GEN_W-1:0] r_gen_cnt;

  // Completed generations since the last config load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_cnt <= '0;
    end else if (w_state_nxt == IDLE) begin
      if (r_state == SIM_BUSY) begin
        r_gen_cnt <= r_gen_cnt + GEN_W'(1);
      end else if (r_state == LOAD_BUSY || r_state == INIT_WAIT) begin
        r_gen_cnt <= '0;
      end
    end
  end

  assign o_gen_cnt = r_gen_cnt;
`else
  assign o_gen_cnt = '0;
`endif

  assign o_nfi_go   = r_nfi_go;
  assign o_fcl_go   = r_fcl_go;
  assign o_load_req = r_load_req;
  assign o_paused   = r_paused;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with behavioural simulator/loader busy responders.
module tb_gen_scheduler;
  import gen_scheduler_pkg::*;

`ifdef GEN_SCHED_GEN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [4:0] M_FRAME  = 5'b00001;
  localparam logic [4:0] M_TOGGLE = 5'b00010;
  localparam logic [4:0] M_STEP   = 5'b00100;
  localparam logic [4:0] M_CFG1   = 5'b01000;
  localparam logic [4:0] M_CFG2   = 5'b10000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    cmd;
  logic          i_nfi_busy, i_fcl_busy;
  logic          o_nfi_go, o_fcl_go, o_paused;
  load_cfg_req_t o_load_req;
  logic [15:0]   o_gen_cnt;

  int n_vec = 0, n_bad = 0, n_viol = 0;
  int nfi_cnt = 0, fcl_cnt = 0, nfi_at_fcl = 0;
  int nfi_len = 3, fcl_len = 4;
  int nl = 0, fl = 0;
  load_cfg_req_t last_req = NO_REQ;

  gen_scheduler #(.FRAMES_PER_GEN(4), .GEN_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_cmd_toggle_pause(cmd[1]),
    .i_cmd_step        (cmd[2]),
    .i_cmd_load_cfg_1  (cmd[3]),
    .i_cmd_load_cfg_2  (cmd[4]),
    .i_frame_start     (cmd[0]),
    .i_nfi_busy        (i_nfi_busy),
    .i_fcl_busy        (i_fcl_busy),
    .o_nfi_go          (o_nfi_go),
    .o_fcl_go          (o_fcl_go),
    .o_load_req        (o_load_req),
    .o_paused          (o_paused),
    .o_gen_cnt         (o_gen_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] m);
    @(negedge clk);
    cmd = m;
    @(negedge clk);
    cmd = '0;
  endtask

  // Responders and protocol monitor: busy follows each go for a set number of cycles.
  initial begin
    i_nfi_busy = 1'b0;
    i_fcl_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        nl = 0;
        fl = 0;
        i_nfi_busy = 1'b0;
        i_fcl_busy = 1'b0;
      end else begin
        if (o_nfi_go && o_fcl_go) n_viol++;
        if ((o_nfi_go || o_fcl_go) && (i_nfi_busy || i_fcl_busy)) n_viol++;
        if (o_nfi_go) begin
          nfi_cnt++;
          nl = nfi_len;
        end
        if (o_fcl_go) begin
          fcl_cnt++;
          last_req   = o_load_req;
          nfi_at_fcl = nfi_cnt;
          fl = fcl_len;
        end
        i_nfi_busy = (nl != 0);
        i_fcl_busy = (fl != 0);
        if (nl != 0) nl--;
        if (fl != 0) fl--;
      end
    end
  end

  initial begin
    int n0, f0;
    rst_n = 1'b0;
    cmd   = '0;

    // Reset values and the MEM_INIT load after release
    wait_cyc(3);
    chk("rst_nfi_go", 32'(o_nfi_go), 32'd0);
    chk("rst_fcl_go", 32'(o_fcl_go), 32'd0);
    chk("rst_load_req", 32'(o_load_req), 32'(NO_REQ));
    chk("rst_paused", 32'(o_paused), 32'd1);
    chk("rst_gen_cnt", 32'(o_gen_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("init_go", 32'(o_fcl_go), 32'd1);
    chk("init_req", 32'(o_load_req), 32'(MEM_INIT));
    @(posedge clk); #2;
    chk("init_go_one_cycle", 32'(o_fcl_go), 32'd0);
    chk("init_req_held", 32'(o_load_req), 32'(MEM_INIT));
    wait_cyc(12);
    chk("init_fcl_cnt", 32'(fcl_cnt), 32'd1);
    chk("init_idle_req", 32'(o_load_req), 32'(NO_REQ));
    chk("init_paused", 32'(o_paused), 32'd1);
    chk("init_no_nfi", 32'(nfi_cnt), 32'd0);

    // Free running: one generation every 4th frame
    pulse(M_TOGGLE);
    chk("run_paused", 32'(o_paused), 32'd0);
    for (int i = 0; i < 12; i++) begin
      pulse(M_FRAME);
      chk($sformatf("run_go_%0d", i), 32'(nfi_cnt), 32'((i + 1) / 4));
      wait_cyc(6);
    end
    chk("run_gen_cnt", 32'(o_gen_cnt), CNT_EN ? 32'd3 : 32'd0);

    // cfg_2 arriving during SIM_BUSY is held until the generation finishes
    nfi_len = 12;
    for (int i = 0; i < 4; i++) begin
      pulse(M_FRAME);
      wait_cyc(2);
    end
    n0 = nfi_cnt;
    f0 = fcl_cnt;
    chk("busy_gen_started", 32'(n0), 32'd4);
    pulse(M_CFG2);
    wait_cyc(2);
    chk("busy_no_fcl", 32'(fcl_cnt), 32'(f0));
    wait_cyc(20);
    chk("busy_fcl_after", 32'(fcl_cnt), 32'(f0 + 1));
    chk("busy_fcl_req", 32'(last_req), 32'(CFG_2));
    chk("busy_fcl_order", 32'(nfi_at_fcl), 32'(n0));
    chk("busy_gen_cnt_clr", 32'(o_gen_cnt), 32'd0);
    chk("busy_req_idle", 32'(o_load_req), 32'(NO_REQ));
    nfi_len = 3;

    // Simultaneous cfg pulses resolve to CFG_1
    pulse(M_TOGGLE);
    chk("pause_again", 32'(o_paused), 32'd1);
    f0 = fcl_cnt;
    pulse(M_CFG1 | M_CFG2);
    wait_cyc(12);
    chk("both_fcl_cnt", 32'(fcl_cnt), 32'(f0 + 1));
    chk("both_req", 32'(last_req), 32'(CFG_1));

    // Paused: frames start nothing, steps start one generation each
    n0 = nfi_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse(M_FRAME);
      wait_cyc(1);
    end
    chk("paused_frames", 32'(nfi_cnt), 32'(n0));
    pulse(M_STEP);
    wait_cyc(10);
    chk("step_1", 32'(nfi_cnt), 32'(n0 + 1));
    pulse(M_STEP);
    wait_cyc(10);
    chk("step_2", 32'(nfi_cnt), 32'(n0 + 2));
    chk("step_gen_cnt", 32'(o_gen_cnt), CNT_EN ? 32'd2 : 32'd0);
    pulse(M_TOGGLE);
    chk("resume", 32'(o_paused), 32'd0);
    pulse(M_STEP);
    wait_cyc(10);
    chk("step_running", 32'(nfi_cnt), 32'(n0 + 2));

    // Reset in the middle of SIM_BUSY
    nfi_len = 12;
    for (int i = 0; i < 4; i++) begin
      pulse(M_FRAME);
      wait_cyc(1);
    end
    n0 = nfi_cnt;
    chk("mid_gen_started", 32'(n0), 32'(nfi_at_fcl + 3));
    wait_cyc(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_nfi_go", 32'(o_nfi_go), 32'd0);
    chk("mid_rst_fcl_go", 32'(o_fcl_go), 32'd0);
    chk("mid_rst_req", 32'(o_load_req), 32'(NO_REQ));
    chk("mid_rst_paused", 32'(o_paused), 32'd1);
    chk("mid_rst_gen_cnt", 32'(o_gen_cnt), 32'd0);
    nfi_len = 3;
    f0 = fcl_cnt;
    wait_cyc(2);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("mid_init_go", 32'(o_fcl_go), 32'd1);
    chk("mid_init_req", 32'(o_load_req), 32'(MEM_INIT));
    wait_cyc(12);
    chk("mid_fcl_cnt", 32'(fcl_cnt), 32'(f0 + 1));
    chk("mid_nfi_cnt", 32'(nfi_cnt), 32'(n0));
    chk("mid_idle_req", 32'(o_load_req), 32'(NO_REQ));

    chk("go_protocol", 32'(n_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
